// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port and burst stream bundle for fifo_burst_reader
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 8
);
  localparam int CW = $clog2(FIFO_SIZE) + 1;

  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output fifo_rd_en, m_valid, m_data, m_last,
    input  fifo_data, fifo_empty, fifo_count, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, m_last,
    output fifo_data, fifo_empty, fifo_count, m_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains sync_fifo into valid/ready bursts with full-length and timeout starts
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  fifo_burst_reader_if.master bus,
  output logic                busy
);
  localparam int CW = $clog2(FIFO_SIZE) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
  localparam logic [TW-1:0] TIMEOUT_C   = TW'(TIMEOUT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [CW-1:0]         pop_left, pop_left_nxt;
  logic [CW-1:0]         beat_left, beat_left_nxt;
  logic                  inflight;
  logic [1:0]            buf_cnt, buf_cnt_nxt;
  logic [DATA_WIDTH-1:0] ob [3];
  logic [DATA_WIDTH-1:0] ob_nxt [3];
  logic                  rd_en;
  logic                  accept;
  logic [1:0]            wr_idx;

  // Pops are throttled by buffer room only, so m_ready never reaches fifo_rd_en combinationally
  assign rd_en  = (state == BURST) && (pop_left != '0) && !bus.fifo_empty &&
                  (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd3);
  assign accept = (buf_cnt != 2'd0) && bus.m_ready;

  always_comb begin
    state_nxt     = state;
    timer_nxt     = '0;
    pop_left_nxt  = pop_left;
    beat_left_nxt = beat_left;
    case (state)
      IDLE: begin
        if (enable && (bus.fifo_count >= BURST_LEN_C)) begin
          state_nxt     = BURST;
          pop_left_nxt  = BURST_LEN_C;
          beat_left_nxt = BURST_LEN_C;
        end else if (enable && (bus.fifo_count != '0) && (timer == TIMEOUT_C)) begin
          state_nxt     = BURST;
          pop_left_nxt  = bus.fifo_count;
          beat_left_nxt = bus.fifo_count;
        end else if (enable && (bus.fifo_count != '0)) begin
          timer_nxt = timer + TW'(1);
        end
      end
      BURST: begin
        if (rd_en) pop_left_nxt = pop_left - CW'(1);
        if (accept) begin
          beat_left_nxt = beat_left - CW'(1);
          if (beat_left == CW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Head-shifting buffer: a returning word lands just behind whatever survives this cycle's accept
  always_comb begin
    for (int i = 0; i < 3; i++) ob_nxt[i] = ob[i];
    if (accept) begin
      ob_nxt[0] = ob[1];
      ob_nxt[1] = ob[2];
    end
    wr_idx = accept ? (buf_cnt - 2'd1) : buf_cnt;
    if (inflight) begin
      case (wr_idx)
        2'd0:    ob_nxt[0] = bus.fifo_data;
        2'd1:    ob_nxt[1] = bus.fifo_data;
        2'd2:    ob_nxt[2] = bus.fifo_data;
        default: ;
      endcase
    end
    buf_cnt_nxt = buf_cnt + {1'b0, inflight} - {1'b0, accept};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      pop_left  <= '0;
      beat_left <= '0;
      inflight  <= 1'b0;
      buf_cnt   <= '0;
      for (int i = 0; i < 3; i++) ob[i] <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      pop_left  <= pop_left_nxt;
      beat_left <= beat_left_nxt;
      inflight  <= rd_en;
      buf_cnt   <= buf_cnt_nxt;
      for (int i = 0; i < 3; i++) ob[i] <= ob_nxt[i];
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (buf_cnt != 2'd0);
  assign bus.m_data     = ob[0];
  assign bus.m_last     = (buf_cnt != 2'd0) && (beat_left == CW'(1));
  assign busy           = (state == BURST);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader with a sync_fifo model
module tb_fifo_burst_reader;
  logic       clk;
  logic       reset;
  logic       enable;
  logic       m_ready;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       busy;

  fifo_burst_reader_if #(.DATA_WIDTH(8), .FIFO_SIZE(8)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(8), .FIFO_SIZE(8), .BURST_LEN(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sync_fifo model: registered data_out, one cycle after the pop
  logic [7:0] fmem [8];
  logic [2:0] fhead, ftail;
  logic [3:0] fcnt;
  logic [7:0] fdout;
  always @(posedge clk or posedge reset) begin : fifo_model
    logic rd, wr;
    if (reset) begin
      fhead <= '0; ftail <= '0; fcnt <= '0; fdout <= '0;
    end else begin
      rd = bus.fifo_rd_en && (fcnt != 0);
      wr = wr_en && (fcnt != 8);
      if (rd) begin
        fdout <= fmem[fhead];
        fhead <= fhead + 3'd1;
      end
      if (wr) begin
        fmem[ftail] <= wr_data;
        ftail <= ftail + 3'd1;
      end
      fcnt <= fcnt + 4'(wr) - 4'(rd);
    end
  end
  assign bus.fifo_data  = fdout;
  assign bus.fifo_empty = (fcnt == 0);
  assign bus.fifo_count = fcnt;
  assign bus.m_ready    = m_ready;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] bq [$];
  logic       lq [$];
  int         cq [$];
  int pops = 0, udf = 0, hold_err = 0, out_cnt = 0, max_out = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
      out_cnt    = 0;
    end else begin
      if (stall_prev && !(bus.m_valid === 1'b1 && bus.m_data === hold_data && bus.m_last === hold_last))
        hold_err++;
      if (bus.fifo_rd_en) begin
        pops++;
        if (bus.fifo_empty) udf++;
      end
      out_cnt = out_cnt + int'(bus.fifo_rd_en) - int'(bus.m_valid && m_ready);
      if (out_cnt > max_out) max_out = out_cnt;
      if (bus.m_valid && m_ready) begin
        bq.push_back(bus.m_data);
        lq.push_back(bus.m_last);
        cq.push_back(cyc);
      end
      stall_prev = bus.m_valid && !m_ready;
      hold_data  = bus.m_data;
      hold_last  = bus.m_last;
    end
  end

  int cmps = 0;
  int mism = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    bq.delete();
    lq.delete();
    cq.delete();
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget, input bit toggle);
    int k;
    k = 0;
    while (bq.size() < n && k < budget) begin
      if (toggle) m_ready = ~m_ready;
      step();
      k++;
    end
    check(tag, 32'(bq.size() >= n), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0;
    int k;
    logic [11:0] lastv;
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    idle(2);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: full burst of four, latency from the decision cycle
    enable = 1'b1; m_ready = 1'b1; clear_q();
    c0 = cyc;
    write_words(8'hA0, 4);
    check("t1_busy_decision", 32'(busy), 32'd0);
    step();
    check("t1_busy_t1", 32'(busy), 32'd1);
    check("t1_rd_en_t1", 32'(bus.fifo_rd_en), 32'd1);
    step();
    check("t1_valid_t2", 32'(bus.m_valid), 32'd0);
    step();
    check("t1_valid_t3", 32'(bus.m_valid), 32'd1);
    check("t1_data_t3", 32'(bus.m_data), 32'hA0);
    wait_beats("t1_beats", 4, 40, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("t1_data%0d", i), 32'(bq[i]), 32'hA0 + 32'(i));
    check("t1_last", {28'd0, lq[3], lq[2], lq[1], lq[0]}, 32'b1000);
    check("t1_first_cyc", 32'(cq[0]), 32'(c0 + 7));
    check("t1_end_cyc", 32'(cq[3]), 32'(c0 + 10));
    idle(4);

    // 2: partial burst after the idle timeout
    clear_q();
    c0 = cyc;
    write_words(8'hB0, 2);
    wait_beats("t2_beats", 2, 60, 1'b0);
    check("t2_first_cyc", 32'(cq[0]), 32'(c0 + 20));
    check("t2_data", {16'd0, bq[0], bq[1]}, 32'hB0B1);
    check("t2_last", {30'd0, lq[1], lq[0]}, 32'b10);
    idle(30);
    check("t2_no_extra", 32'(bq.size()), 32'd2);

    // 4a: enable low holds eight stored words
    enable = 1'b0; clear_q();
    k = pops;
    write_words(8'hC0, 8);
    idle(30);
    check("t4_no_pops", 32'(pops - k), 32'd0);
    check("t4_no_beats", 32'(bq.size()), 32'd0);
    check("t4_count", 32'(fcnt), 32'd8);

    // 3: resume under toggling backpressure
    enable = 1'b1; m_ready = 1'b0; max_out = 0;
    wait_beats("t3_beats", 8, 120, 1'b1);
    m_ready = 1'b1;
    idle(10);
    check("t3_beat_cnt", 32'(bq.size()), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t3_data%0d", i), 32'(bq[i]), 32'hC0 + 32'(i));
    lastv = '0;
    for (int i = 0; i < 8; i++) lastv[i] = lq[i];
    check("t3_last", 32'(lastv), 32'h88);
    check("t3_hold", 32'(hold_err), 32'd0);
    check("t3_outstanding", 32'(max_out <= 3), 32'd1);
    check("t3_pops", 32'(pops - k), 32'd8);

    // 4b: enable dropped mid-burst lets only the current burst finish
    enable = 1'b0; clear_q();
    write_words(8'hD0, 8);
    enable = 1'b1;
    k = 0;
    while (!busy && k < 10) begin step(); k++; end
    check("t4b_started", 32'(busy), 32'd1);
    step();
    step();
    enable = 1'b0;
    wait_beats("t4b_beats", 4, 40, 1'b0);
    idle(30);
    check("t4b_beat_cnt", 32'(bq.size()), 32'd4);
    check("t4b_data", {bq[0], bq[1], bq[2], bq[3]}, 32'hD0D1D2D3);
    check("t4b_busy", 32'(busy), 32'd0);
    check("t4b_count", 32'(fcnt), 32'd4);
    enable = 1'b1;
    wait_beats("t4b_resume", 8, 40, 1'b0);
    check("t4b_data2", {bq[4], bq[5], bq[6], bq[7]}, 32'hD4D5D6D7);
    idle(4);

    // 5: reset on the second beat
    enable = 1'b0; clear_q();
    write_words(8'hE0, 4);
    enable = 1'b1;
    k = 0;
    while (bq.size() < 1 && k < 40) begin step(); k++; end
    check("t5_beat1", 32'(bq.size()), 32'd1);
    check("t5_valid_b2", 32'(bus.m_valid), 32'd1);
    check("t5_data_b2", 32'(bus.m_data), 32'hE1);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 32'(bus.m_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_last", 32'(bus.m_last), 32'd0);
    idle(2);
    reset = 1'b0;
    step();
    check("t5_idle", 32'(busy), 32'd0);
    idle(30);
    check("t5_no_stale", 32'(bq.size()), 32'd1);
    write_words(8'hF0, 4);
    wait_beats("t5_after", 5, 40, 1'b0);
    check("t5_after_data", {bq[1], bq[2], bq[3], bq[4]}, 32'hF0F1F2F3);
    idle(4);

    // 6: one write per clock with the sink always ready
    clear_q();
    c0 = cyc;
    write_words(8'h60, 12);
    wait_beats("t6_beats", 12, 80, 1'b0);
    for (int i = 0; i < 12; i++) check($sformatf("t6_data%0d", i), 32'(bq[i]), 32'h60 + 32'(i));
    lastv = '0;
    for (int i = 0; i < 12; i++) lastv[i] = lq[i];
    check("t6_last", 32'(lastv), 32'h888);
    check("t6_b1_start", 32'(cq[0]), 32'(c0 + 7));
    check("t6_b1_end", 32'(cq[3]), 32'(c0 + 10));
    check("t6_b2_start", 32'(cq[4]), 32'(c0 + 14));
    check("t6_b2_end", 32'(cq[7]), 32'(c0 + 17));
    check("t6_b3_start", 32'(cq[8]), 32'(c0 + 21));
    check("t6_b3_end", 32'(cq[11]), 32'(c0 + 24));
    check("underflow_pops", 32'(udf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, mism);
    $finish;
  end
endmodule
